// File: rtl/pheap_level_stage.sv
// P-heap level pipeline stage for levels 2..LEVELS: owns one level's node memory,
// applies LEQ/DEQ commands from the level above and steers the displaced value downward.
package pheap_types_pkg;
    localparam int unsigned LEVELS = 4;
    localparam int unsigned PV_W   = 32;

    typedef enum logic {LEQ = 1'b0, DEQ = 1'b1} opcode_t;
    typedef enum logic [1:0] {DONE = 2'd0, WAIT = 2'd1, NEXT_LEVEL = 2'd2} done_t;

    typedef struct packed {
        logic [PV_W-1:0]   pv;
        logic [LEVELS-1:0] capacity;
        logic              active;
    } entry_t;
endpackage

module pheap_level_stage
    import pheap_types_pkg::*;
#(
    parameter int unsigned LEVEL  = 2,
    parameter int unsigned LEVELS = pheap_types_pkg::LEVELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  opcode_t           op,
    input  logic [31:0]       in,
    input  logic [LEVELS-1:0] addrIn,
    input  logic [LEVELS-1:0] parRaddr,
    output entry_t            parBotL,
    output entry_t            parBotR,
    input  entry_t            rBotL,
    input  entry_t            rBotR,
    output logic [LEVELS-1:0] raddrBot,
    output logic              ready,
    output done_t             done,
    output logic              endPos,
    output logic [LEVELS-1:0] addrOut,
    output logic [31:0]       out,
    output logic              err
);
    localparam int unsigned NODES = 2 ** (LEVEL - 1);
    localparam int unsigned IDX_W = LEVEL - 1;
    localparam logic [LEVELS-1:0] CAP_RST = LEVELS'(2 ** (LEVELS - LEVEL + 1) - 1);
    localparam entry_t RST_ENTRY = '{pv: '0, capacity: CAP_RST, active: 1'b0};

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t              state, state_nxt;
    entry_t              mem [NODES];
    entry_t              node_q;
    logic [LEVELS-2:0]   addr_q;
    opcode_t             op_q;
    logic [31:0]         in_q;
    logic [IDX_W-1:0]    idx_in, idx_q, idx_l, idx_r;
    logic                accept;
    logic                wr_en;
    entry_t              wr_data;
    done_t               done_nxt;
    logic [31:0]         out_nxt;
    logic                endpos_nxt, err_nxt, ready_nxt;
    logic [LEVELS-1:0]   addrout_nxt;
    logic                unused;

    assign accept   = (state == IDLE) && start;
    assign idx_in   = addrIn[IDX_W-1:0];
    assign idx_q    = addr_q[IDX_W-1:0];
    assign idx_l    = IDX_W'({parRaddr, 1'b0});
    assign idx_r    = IDX_W'({parRaddr, 1'b1});
    // Pair address reaches the next level in the start cycle so its children are ready in EXEC.
    assign raddrBot = accept ? addrIn : '0;
    assign unused   = ^{rBotR.capacity, addr_q};

    // Next-state, node update and result computation
    always_comb begin
        state_nxt   = state;
        done_nxt    = DONE;
        out_nxt     = '0;
        endpos_nxt  = 1'b0;
        err_nxt     = 1'b0;
        ready_nxt   = 1'b1;
        addrout_nxt = '0;
        wr_en       = 1'b0;
        wr_data     = node_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = EXEC;
                    done_nxt  = WAIT;
                    ready_nxt = 1'b0;
                end
            end
            EXEC: begin
                state_nxt = IDLE;
                if (op_q == LEQ) begin
                    if (!node_q.active) begin
                        wr_en   = 1'b1;
                        wr_data = '{pv: in_q, capacity: node_q.capacity - LEVELS'(1), active: 1'b1};
                    end else if (node_q.capacity == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        wr_en            = 1'b1;
                        wr_data.capacity = node_q.capacity - LEVELS'(1);
                        done_nxt         = NEXT_LEVEL;
                        endpos_nxt       = (rBotL.capacity == '0);
                        // Ties keep the resident value and push the incoming one down.
                        if (in_q > node_q.pv) begin
                            wr_data.pv = in_q;
                            out_nxt    = node_q.pv;
                        end else begin
                            out_nxt    = in_q;
                        end
                    end
                end else begin
                    if (!node_q.active) begin
                        err_nxt = 1'b1;
                    end else begin
                        wr_en            = 1'b1;
                        out_nxt          = node_q.pv;
                        wr_data.capacity = node_q.capacity + LEVELS'(1);
                        if ((LEVEL == LEVELS) || (!rBotL.active && !rBotR.active)) begin
                            wr_data.pv     = '0;
                            wr_data.active = 1'b0;
                        end else if (rBotL.active && (!rBotR.active || rBotL.pv >= rBotR.pv)) begin
                            wr_data.pv = rBotL.pv;
                            done_nxt   = NEXT_LEVEL;
                        end else begin
                            wr_data.pv = rBotR.pv;
                            endpos_nxt = 1'b1;
                            done_nxt   = NEXT_LEVEL;
                        end
                    end
                end
                addrout_nxt = LEVELS'({addr_q, endpos_nxt});
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, captured command and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            node_q  <= RST_ENTRY;
            addr_q  <= '0;
            op_q    <= LEQ;
            in_q    <= '0;
            done    <= DONE;
            out     <= '0;
            endPos  <= 1'b0;
            addrOut <= '0;
            err     <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            out     <= out_nxt;
            endPos  <= endpos_nxt;
            addrOut <= addrout_nxt;
            err     <= err_nxt;
            ready   <= ready_nxt;
            if (accept) begin
                node_q <= mem[idx_in];
                addr_q <= addrIn[LEVELS-2:0];
                op_q   <= op;
                in_q   <= in;
            end
        end
    end

    // Node memory and child-pair read port with write-forwarding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NODES; i++) mem[i] <= RST_ENTRY;
            parBotL <= RST_ENTRY;
            parBotR <= RST_ENTRY;
        end else begin
            if (wr_en) mem[idx_q] <= wr_data;
            parBotL <= (wr_en && idx_q == idx_l) ? wr_data : mem[idx_l];
            parBotR <= (wr_en && idx_q == idx_r) ? wr_data : mem[idx_r];
        end
    end
endmodule

// File: tb/tb_pheap_level_stage.sv
// Self-checking bench for pheap_level_stage (LEVEL=3 of 4): directed vector table,
// reset/ignored-start corner sequences and randomized commands against a node-array model.
module tb_pheap_level_stage;
    import pheap_types_pkg::*;

    localparam int unsigned LEVEL = 3;
    localparam int unsigned LV    = 4;
    localparam int unsigned NODES = 4;
    localparam int unsigned CAPR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    opcode_t       op;
    logic [31:0]   in;
    logic [LV-1:0] addrIn, parRaddr, raddrBot, addrOut;
    entry_t        parBotL, parBotR, rBotL, rBotR;
    logic          ready, endPos, err;
    done_t         done;
    logic [31:0]   out;

    pheap_level_stage #(.LEVEL(LEVEL), .LEVELS(LV)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in(in), .addrIn(addrIn),
        .parRaddr(parRaddr), .parBotL(parBotL), .parBotR(parBotR), .rBotL(rBotL),
        .rBotR(rBotR), .raddrBot(raddrBot), .ready(ready), .done(done),
        .endPos(endPos), .addrOut(addrOut), .out(out), .err(err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] pv;
        int unsigned cap;
        bit          act;
    } mnode_t;
    mnode_t model [NODES];

    typedef struct {
        opcode_t     op;
        logic [31:0] v;
        int          a;
        entry_t      l, r;
        done_t       d;
        logic [31:0] o;
        logic        ep;
        logic [3:0]  ao;
        logic        e;
        entry_t      node;
    } vec_t;
    vec_t tbl [12];

    function automatic entry_t mk(input logic [31:0] pv, input int unsigned cap, input bit act);
        mk = '{pv: pv, capacity: LV'(cap), active: act};
    endfunction

    function automatic entry_t model_entry(input int a);
        model_entry = mk(model[a].pv, model[a].cap, model[a].act);
    endfunction

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NODES; i++) model[i] = '{pv: 32'd0, cap: CAPR, act: 1'b0};
    endfunction

    // Behavioural LEQ/DEQ rules applied to one model node.
    function automatic void model_step(input opcode_t o, input logic [31:0] v, input int a,
                                       input entry_t l, input entry_t r,
                                       output done_t d, output logic [31:0] ov, output logic ep,
                                       output logic [3:0] ao, output logic e);
        mnode_t m = model[a];
        logic [31:0] hi, lo;
        d = DONE; ov = 0; ep = 0; e = 0;
        if (o == LEQ) begin
            if (!m.act) m = '{pv: v, cap: m.cap - 1, act: 1'b1};
            else if (m.cap == 0) e = 1;
            else begin
                hi = (v > m.pv) ? v : m.pv;
                lo = (v > m.pv) ? m.pv : v;
                ov = lo; m.pv = hi; m.cap = m.cap - 1;
                d = NEXT_LEVEL; ep = (l.capacity == 0);
            end
        end else begin
            if (!m.act) e = 1;
            else begin
                ov = m.pv; m.cap = m.cap + 1;
                if (!l.active && !r.active) begin
                    m.pv = 0; m.act = 0;
                end else begin
                    ep = r.active && (!l.active || r.pv > l.pv);
                    m.pv = ep ? r.pv : l.pv;
                    d = NEXT_LEVEL;
                end
            end
        end
        model[a] = m;
        ao = 4'(a * 2 + int'(ep));
    endfunction

    // One command: start cycle, EXEC cycle (optionally with an illegal start), result sample.
    task automatic run_cmd(input opcode_t o, input logic [31:0] v, input int a,
                           input entry_t l, input entry_t r, input bit junk,
                           output done_t d, output logic [31:0] ov, output logic ep,
                           output logic [3:0] ao, output logic e,
                           output entry_t node_seen, output entry_t sib_seen);
        @(negedge clk);
        start = 1'b1; op = o; in = v; addrIn = LV'(a); rBotL = l; rBotR = r;
        #1 check("raddrBot_start", 64'(raddrBot), 64'(a));
        @(posedge clk);
        #1 check("done_wait", 64'(done), 64'(WAIT));
        check("ready_low", 64'(ready), 64'd0);
        @(negedge clk);
        parRaddr = LV'(a >> 1);
        if (junk) begin
            op = (o == LEQ) ? DEQ : LEQ; addrIn = LV'((a + 1) % NODES); in = $urandom;
        end else begin
            start = 1'b0;
            #1 check("raddrBot_exec", 64'(raddrBot), 64'd0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        d = done; ov = out; ep = endPos; ao = addrOut[3:0]; e = err;
        node_seen = a[0] ? parBotR : parBotL;
        sib_seen  = a[0] ? parBotL : parBotR;
        if (junk) begin
            @(posedge clk);
            #1 check("start_in_exec_ignored_done", 64'(done), 64'(DONE));
            check("start_in_exec_ignored_ready", 64'(ready), 64'd1);
        end
    endtask

    task automatic read_pair(input int p);
        @(negedge clk);
        parRaddr = LV'(p);
        @(posedge clk);
        #1 check("readback_L", 64'(parBotL), 64'(model_entry(2 * p)));
        check("readback_R", 64'(parBotR), 64'(model_entry(2 * p + 1)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        done_t d, md;
        logic [31:0] ov, mo;
        logic ep, e, mep, me;
        logic [3:0] ao, mao;
        entry_t ns, ss, l, r;
        opcode_t o;
        logic [31:0] v;
        int a;
        bit junk;

        rst = 1'b0; start = 1'b0; op = LEQ; in = '0; addrIn = '0; parRaddr = '0;
        rBotL = mk(0, 0, 0); rBotR = mk(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("rst_parBotL", 64'(parBotL), 64'(mk(0, CAPR, 0)));
        check("rst_parBotR", 64'(parBotR), 64'(mk(0, CAPR, 0)));
        check("rst_done", 64'(done), 64'(DONE));
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_out_err", 64'({out, err, endPos, addrOut}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        tbl[0]  = '{LEQ, 10, 0, mk(0,1,0), mk(0,1,0), DONE,       10'd0, 0, 0, 0, mk(10,2,1)};
        tbl[1]  = '{LEQ,  5, 0, mk(0,1,0), mk(0,1,0), NEXT_LEVEL,  5,    0, 0, 0, mk(10,1,1)};
        tbl[2]  = '{LEQ, 20, 0, mk(0,0,1), mk(0,1,0), NEXT_LEVEL, 10,    1, 1, 0, mk(20,0,1)};
        tbl[3]  = '{LEQ,  7, 0, mk(0,1,0), mk(0,1,0), DONE,        0,    0, 0, 1, mk(20,0,1)};
        tbl[4]  = '{DEQ,  0, 0, mk(7,1,1), mk(9,1,1), NEXT_LEVEL, 20,    1, 1, 0, mk(9,1,1)};
        tbl[5]  = '{DEQ,  0, 0, mk(9,0,1), mk(9,0,1), NEXT_LEVEL,  9,    0, 0, 0, mk(9,2,1)};
        tbl[6]  = '{DEQ,  0, 0, mk(0,1,0), mk(0,1,0), DONE,        9,    0, 0, 0, mk(0,3,0)};
        tbl[7]  = '{DEQ,  0, 0, mk(0,1,0), mk(0,1,0), DONE,        0,    0, 0, 1, mk(0,3,0)};
        tbl[8]  = '{LEQ, 30, 1, mk(0,1,0), mk(0,1,0), DONE,        0,    0, 2, 0, mk(30,2,1)};
        tbl[9]  = '{LEQ,  1, 1, mk(0,1,0), mk(0,1,0), NEXT_LEVEL,  1,    0, 2, 0, mk(30,1,1)};
        tbl[10] = '{LEQ,  2, 1, mk(0,1,0), mk(0,1,0), NEXT_LEVEL,  2,    0, 2, 0, mk(30,0,1)};
        tbl[11] = '{DEQ,  0, 1, mk(7,1,1), mk(9,1,1), NEXT_LEVEL, 30,    1, 3, 0, mk(9,1,1)};

        for (int i = 0; i < 12; i++) begin
            model_step(tbl[i].op, tbl[i].v, tbl[i].a, tbl[i].l, tbl[i].r, md, mo, mep, mao, me);
            run_cmd(tbl[i].op, tbl[i].v, tbl[i].a, tbl[i].l, tbl[i].r, (i == 1 || i == 7),
                    d, ov, ep, ao, e, ns, ss);
            check($sformatf("vec%0d_done", i), 64'(d), 64'(tbl[i].d));
            check($sformatf("vec%0d_out", i), 64'(ov), 64'(tbl[i].o));
            check($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].e));
            check($sformatf("vec%0d_node_fwd", i), 64'(ns), 64'(tbl[i].node));
            check($sformatf("vec%0d_sibling", i), 64'(ss), 64'(model_entry(tbl[i].a ^ 1)));
            if (tbl[i].d == NEXT_LEVEL) begin
                check($sformatf("vec%0d_endPos", i), 64'(ep), 64'(tbl[i].ep));
                check($sformatf("vec%0d_addrOut", i), 64'(ao), 64'(tbl[i].ao));
            end
            if (e) begin
                @(posedge clk);
                #1 check($sformatf("vec%0d_err_pulse", i), 64'(err), 64'd0);
            end
        end
        read_pair(0);
        read_pair(1);

        // Reset asserted during EXEC
        @(negedge clk);
        start = 1'b1; op = LEQ; in = 50; addrIn = 2;
        @(posedge clk);
        #1 start = 1'b0;
        check("mid_exec_pre_done", 64'(done), 64'(WAIT));
        #2 rst = 1'b0;
        #1 check("mid_rst_done", 64'(done), 64'(DONE));
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_outs", 64'({out, err, endPos, addrOut, raddrBot}), 64'd0);
        check("mid_rst_parBotL", 64'(parBotL), 64'(mk(0, CAPR, 0)));
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        read_pair(0);
        read_pair(1);
        model_step(LEQ, 50, 2, mk(0,1,0), mk(0,1,0), md, mo, mep, mao, me);
        run_cmd(LEQ, 50, 2, mk(0,1,0), mk(0,1,0), 1'b0, d, ov, ep, ao, e, ns, ss);
        check("post_rst_done", 64'(d), 64'(DONE));
        check("post_rst_node", 64'(ns), 64'(mk(50, 2, 1)));

        // Randomized commands against the model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            o = ($urandom_range(0, 9) < 6) ? LEQ : DEQ;
            a = int'($urandom_range(0, NODES - 1));
            v = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20));
            l = mk(32'($urandom_range(0, 12)), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
            r = mk(32'($urandom_range(0, 12)), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
            junk = ($urandom_range(0, 7) == 0);
            model_step(o, v, a, l, r, md, mo, mep, mao, me);
            run_cmd(o, v, a, l, r, junk, d, ov, ep, ao, e, ns, ss);
            check("rnd_done", 64'(d), 64'(md));
            check("rnd_out", 64'(ov), 64'(mo));
            check("rnd_err", 64'(e), 64'(me));
            check("rnd_node", 64'(ns), 64'(model_entry(a)));
            check("rnd_sibling", 64'(ss), 64'(model_entry(a ^ 1)));
            if (md == NEXT_LEVEL) begin
                check("rnd_endPos", 64'(ep), 64'(mep));
                check("rnd_addrOut", 64'(ao), 64'(mao));
            end
            if (n % 50 == 49) begin
                read_pair(0);
                read_pair(1);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
